// File: rtl/i2c_bridge_pkg.sv
// Shared definitions for the I2C bridge arbiter: state encoding and default timing limits.
package i2c_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXT   = 3'd1,
    ST_BUF   = 3'd2,
    ST_LOC   = 3'd3,
    ST_LBUF  = 3'd4,
    ST_FAULT = 3'd5
  } arb_state_e;

  localparam int DEF_BUF_CYCLES     = 48;
  localparam int DEF_TIMEOUT_CYCLES = 20000;
  localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// Synchronises both bus sides, forms the wired-AND lines and flags START, STOP and SCL edges.
// Pulses and levels appear 3 clocks after a pin change (2 sync stages + 1 edge register).
module i2c_bus_cond_detect (
  input  logic clock,
  input  logic reset,
  input  logic SCL_m_in,
  input  logic SDA_m_in,
  input  logic SCL_c_in,
  input  logic SDA_c_in,
  output logic start,
  output logic stop,
  output logic scl_edge,
  output logic scl,
  output logic sda
);

  logic [1:0] scl_m_sync, sda_m_sync, scl_c_sync, sda_c_sync;
  logic       scl_now, sda_now;

  // NOTE: every register here uses <= so all stages sample the pre-edge values together.
  // Synchronisers reset to 1 (released bus) so leaving reset cannot fake a START/STOP.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_m_sync <= 2'b11;
      sda_m_sync <= 2'b11;
      scl_c_sync <= 2'b11;
      sda_c_sync <= 2'b11;
    end else begin
      scl_m_sync <= {scl_m_sync[0], SCL_m_in};
      sda_m_sync <= {sda_m_sync[0], SDA_m_in};
      scl_c_sync <= {scl_c_sync[0], SCL_c_in};
      sda_c_sync <= {sda_c_sync[0], SDA_c_in};
    end
  end

  assign scl_now = scl_m_sync[1] & scl_c_sync[1];
  assign sda_now = sda_m_sync[1] & sda_c_sync[1];

  // scl/sda hold the previous synchronised levels, so they double as the edge reference.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl      <= 1'b1;
      sda      <= 1'b1;
      start    <= 1'b0;
      stop     <= 1'b0;
      scl_edge <= 1'b0;
    end else begin
      scl      <= scl_now;
      sda      <= sda_now;
      start    <= scl & scl_now &  sda & ~sda_now;
      stop     <= scl & scl_now & ~sda &  sda_now;
      scl_edge <= scl ^ scl_now;
    end
  end

endmodule

// File: rtl/i2c_bridge_arbiter.sv
// Bus-ownership arbiter for the two-sided I2C repeater; grants the C side to the local master.
// Define I2C_BRIDGE_ARB_TIMEOUT_EN to enable EXT/LOC timeouts and the FAULT state.
module i2c_bridge_arbiter
  import i2c_bridge_pkg::*;
#(
  parameter int BUF_CYCLES     = DEF_BUF_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SCL_m_in,
  input  logic       SDA_m_in,
  input  logic       SCL_c_in,
  input  logic       SDA_c_in,
  input  logic       loc_req,
  input  logic       loc_done,
  output logic       loc_gnt,
  output logic       suppress_outputs,
  output logic       bus_busy,
  output logic       collision,
  output logic       fault,
  output logic [2:0] state_dbg
);

  if ((64'd1 << CNT_W) <= 64'(BUF_CYCLES) || (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W too narrow for BUF_CYCLES/TIMEOUT_CYCLES");
  end

  localparam logic [CNT_W-1:0] BUF_LIM = CNT_W'(BUF_CYCLES);

  logic             start, stop, scl_edge, scl, sda;
  arb_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             collision_n;

  i2c_bus_cond_detect u_detect (
    .clock    (clock),
    .reset    (reset),
    .SCL_m_in (SCL_m_in),
    .SDA_m_in (SDA_m_in),
    .SCL_c_in (SCL_c_in),
    .SDA_c_in (SDA_c_in),
    .start    (start),
    .stop     (stop),
    .scl_edge (scl_edge),
    .scl      (scl),
    .sda      (sda)
  );

  // "Reaching" a limit means the incremented value hits it, so a state with limit N lasts N clocks.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  // NOTE: state_n, cnt_n and collision_n get defaults first so no path leaves them unassigned.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt_inc;
    collision_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (start)        state_n = ST_EXT;
        else if (loc_req) state_n = ST_LOC;
      end
      ST_EXT: begin
        if (stop)          state_n = ST_BUF;
        else if (scl_edge) cnt_n   = '0;
`ifdef I2C_BRIDGE_ARB_TIMEOUT_EN
        else if (cnt_inc >= CNT_W'(TIMEOUT_CYCLES)) state_n = ST_FAULT;
`endif
      end
      ST_BUF, ST_LBUF: begin
        if (start)                  state_n = ST_EXT;
        else if (cnt_inc >= BUF_LIM) state_n = ST_IDLE;
      end
      ST_LOC: begin
        if (loc_done || !loc_req) begin
          state_n = ST_LBUF;
        end else begin
          collision_n = start;
`ifdef I2C_BRIDGE_ARB_TIMEOUT_EN
          if (cnt_inc >= CNT_W'(TIMEOUT_CYCLES)) state_n = ST_FAULT;
`endif
        end
      end
`ifdef I2C_BRIDGE_ARB_TIMEOUT_EN
      ST_FAULT: begin
        if (!(scl && sda))          cnt_n   = '0;
        else if (cnt_inc >= BUF_LIM) state_n = ST_IDLE;
      end
`endif
      default: state_n = ST_BUF;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  // Outputs are decoded from state_n so they change on the same edge as the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_BUF;
      cnt              <= '0;
      loc_gnt          <= 1'b0;
      suppress_outputs <= 1'b1;
      bus_busy         <= 1'b0;
      collision        <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      loc_gnt          <= (state_n == ST_LOC);
      suppress_outputs <= (state_n inside {ST_LOC, ST_LBUF, ST_FAULT});
      bus_busy         <= (state_n inside {ST_EXT, ST_LOC});
      collision        <= collision_n;
    end
  end

`ifdef I2C_BRIDGE_ARB_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) fault <= 1'b0;
    else       fault <= (state_n == ST_FAULT);
  end
`else
  assign fault = 1'b0;
  // Bus levels only feed FAULT recovery, which is absent in this build.
  logic unused_levels;
  assign unused_levels = &{1'b0, scl, sda};
`endif

  assign state_dbg = state;

endmodule

// File: tb/tb_i2c_bridge_arbiter.sv
// Directed self-checking bench for i2c_bridge_arbiter (BUF_CYCLES=48, TIMEOUT_CYCLES=100).
// Expected timing: pin change to FSM reaction 4 clocks; limit N keeps a state for N clocks.
module tb_i2c_bridge_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       SCL_m_in, SDA_m_in, SCL_c_in, SDA_c_in;
  logic       loc_req, loc_done;
  logic       loc_gnt, suppress_outputs, bus_busy, collision, fault;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_EXT = 3'd1, S_BUF = 3'd2,
                         S_LOC = 3'd3, S_LBUF = 3'd4, S_FAULT = 3'd5;

  i2c_bridge_arbiter #(
    .BUF_CYCLES     (48),
    .TIMEOUT_CYCLES (100),
    .CNT_W          (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .SCL_m_in         (SCL_m_in),
    .SDA_m_in         (SDA_m_in),
    .SCL_c_in         (SCL_c_in),
    .SDA_c_in         (SDA_c_in),
    .loc_req          (loc_req),
    .loc_done         (loc_done),
    .loc_gnt          (loc_gnt),
    .suppress_outputs (suppress_outputs),
    .bus_busy         (bus_busy),
    .collision        (collision),
    .fault            (fault),
    .state_dbg        (state_dbg)
  );

  always #5 clock = ~clock;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {SCL_m_in, SDA_m_in, SCL_c_in, SDA_c_in} = 4'b1111;
    loc_req  = 1'b0;
    loc_done = 1'b0;

    // Reset values
    tick(3);
    check("rst_suppress", 16'(suppress_outputs), 16'd1);
    check("rst_state",    16'(state_dbg),        16'(S_BUF));
    check("rst_gnt",      16'(loc_gnt),          16'd0);
    check("rst_busy",     16'(bus_busy),         16'd0);
    check("rst_coll",     16'(collision),        16'd0);
    check("rst_fault",    16'(fault),            16'd0);

    // Release: suppress drops on the first clock, BUF lasts 48 clocks
    reset = 1'b0;
    tick(1);
    check("post_rst_suppress", 16'(suppress_outputs), 16'd0);
    tick(46);
    check("post_rst_buf47", 16'(state_dbg), 16'(S_BUF));
    tick(1);
    check("post_rst_idle48", 16'(state_dbg), 16'(S_IDLE));

    // loc_done outside LOC is ignored
    loc_done = 1'b1;
    tick(1);
    loc_done = 1'b0;
    check("done_in_idle", 16'(state_dbg), 16'(S_IDLE));

    // External transfer: START on M side
    SDA_m_in = 1'b0;
    tick(3);
    check("ext_start_lat3", 16'(state_dbg), 16'(S_IDLE));
    tick(1);
    check("ext_state",    16'(state_dbg),        16'(S_EXT));
    check("ext_busy",     16'(bus_busy),         16'd1);
    check("ext_suppress", 16'(suppress_outputs), 16'd0);
    SCL_m_in = 1'b0;
    tick(4);
    SCL_m_in = 1'b1;
    tick(4);
    SDA_m_in = 1'b1;
    tick(4);
    check("ext_stop_buf", 16'(state_dbg), 16'(S_BUF));
    check("ext_stop_busy", 16'(bus_busy), 16'd0);
    tick(47);
    check("ext_buf47", 16'(state_dbg), 16'(S_BUF));
    tick(1);
    check("ext_idle48", 16'(state_dbg), 16'(S_IDLE));

    // Local grant and release
    loc_req = 1'b1;
    tick(1);
    check("loc_gnt",      16'(loc_gnt),          16'd1);
    check("loc_suppress", 16'(suppress_outputs), 16'd1);
    check("loc_state",    16'(state_dbg),        16'(S_LOC));
    check("loc_busy",     16'(bus_busy),         16'd1);
    tick(5);
    loc_done = 1'b1;
    tick(1);
    loc_done = 1'b0;
    loc_req  = 1'b0;
    check("lbuf_gnt",      16'(loc_gnt),          16'd0);
    check("lbuf_suppress", 16'(suppress_outputs), 16'd1);
    check("lbuf_state",    16'(state_dbg),        16'(S_LBUF));
    tick(47);
    check("lbuf47_suppress", 16'(suppress_outputs), 16'd1);
    tick(1);
    check("lbuf_idle48",      16'(state_dbg),        16'(S_IDLE));
    check("lbuf_idle_suppr",  16'(suppress_outputs), 16'd0);

    // START detection and loc_req on the same cycle: EXT wins, request stays pending
    SDA_m_in = 1'b0;
    tick(3);
    loc_req = 1'b1;
    tick(1);
    check("sim_state", 16'(state_dbg), 16'(S_EXT));
    check("sim_gnt",   16'(loc_gnt),   16'd0);
    SDA_m_in = 1'b1;
    tick(4);
    check("sim_buf", 16'(state_dbg), 16'(S_BUF));
    tick(47);
    check("sim_buf47_gnt", 16'(loc_gnt), 16'd0);
    tick(1);
    check("sim_idle",     16'(state_dbg), 16'(S_IDLE));
    check("sim_idle_gnt", 16'(loc_gnt),   16'd0);
    tick(1);
    check("sim_late_gnt", 16'(loc_gnt),   16'd1);
    check("sim_loc",      16'(state_dbg), 16'(S_LOC));

    // Collision: C-side START while granted
    SDA_c_in = 1'b0;
    tick(3);
    check("coll_pre", 16'(collision), 16'd0);
    tick(1);
    check("coll_pulse", 16'(collision), 16'd1);
    check("coll_state", 16'(state_dbg), 16'(S_LOC));
    check("coll_gnt",   16'(loc_gnt),   16'd1);
    tick(1);
    check("coll_end",   16'(collision), 16'd0);
    check("coll_state2", 16'(state_dbg), 16'(S_LOC));
    SDA_c_in = 1'b1;
    tick(4);
    check("coll_stop_ignored", 16'(state_dbg), 16'(S_LOC));
    loc_req = 1'b0;
    tick(1);
    check("req_fall_lbuf", 16'(state_dbg), 16'(S_LBUF));
    tick(47);
    check("req_fall_lbuf47", 16'(state_dbg), 16'(S_LBUF));
    tick(1);
    check("req_fall_idle", 16'(state_dbg), 16'(S_IDLE));

    // Timeout: START, then SCL held low
    SDA_m_in = 1'b0;
    tick(4);
    check("to_ext", 16'(state_dbg), 16'(S_EXT));
    SCL_m_in = 1'b0;
    tick(103);
    check("to_ext103", 16'(state_dbg), 16'(S_EXT));
    tick(1);
`ifdef I2C_BRIDGE_ARB_TIMEOUT_EN
    check("to_fault_state",    16'(state_dbg),        16'(S_FAULT));
    check("to_fault_flag",     16'(fault),            16'd1);
    check("to_fault_suppress", 16'(suppress_outputs), 16'd1);
    {SCL_m_in, SDA_m_in} = 2'b11;
    tick(50);
    check("fault_hold50", 16'(state_dbg), 16'(S_FAULT));
    tick(1);
    check("fault_idle",  16'(state_dbg), 16'(S_IDLE));
    check("fault_clear", 16'(fault),     16'd0);
`else
    check("nto_state", 16'(state_dbg), 16'(S_EXT));
    check("nto_fault", 16'(fault),     16'd0);
    tick(200);
    check("nto_state_late", 16'(state_dbg), 16'(S_EXT));
    check("nto_fault_late", 16'(fault),     16'd0);
    SCL_m_in = 1'b1;
    tick(4);
    SDA_m_in = 1'b1;
    tick(4);
    check("nto_stop_buf", 16'(state_dbg), 16'(S_BUF));
    tick(48);
    check("nto_idle", 16'(state_dbg), 16'(S_IDLE));
`endif

    // Reset mid-transaction drops the grant on the next edge
    loc_req = 1'b1;
    tick(1);
    check("mid_gnt", 16'(loc_gnt), 16'd1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_gnt",      16'(loc_gnt),          16'd0);
    check("mid_rst_state",    16'(state_dbg),        16'(S_BUF));
    check("mid_rst_suppress", 16'(suppress_outputs), 16'd1);
    reset   = 1'b0;
    loc_req = 1'b0;
    tick(1);
    check("mid_rel_suppress", 16'(suppress_outputs), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
